// File: rtl/traffic_intersection.sv
// Traffic intersection controller: round-robin green/yellow/all-red sequencing
// over NUM_DIRS approaches, with latched pedestrian walk requests and a
// flashing fault/night mode entered and left only through all-red clearance.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   tick       - time-base enable; countdown advances only when high
//   ped_req    - per-approach pedestrian request (level, sampled every cycle)
//   flash_mode - flashing-mode request, honoured at all-red expiry
//   light      - per-approach {red,yellow,green}, slice d at [3d+2:3d]
//   ped_walk   - per-approach walk, only during that approach's green
//   active_dir - approach currently or most recently granted green
module traffic_intersection #(
    parameter int unsigned NUM_DIRS = 2,
    parameter int unsigned TW       = 4,
    parameter int unsigned GREEN_T  = 6,
    parameter int unsigned YELLOW_T = 2,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned FLASH_T  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [NUM_DIRS-1:0]     ped_req,
    input  logic                    flash_mode,
    output logic [3*NUM_DIRS-1:0]   light,
    output logic [NUM_DIRS-1:0]     ped_walk,
    output logic [1:0]              active_dir
);

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_FLASH   = 2'd3
    } state_t;

    localparam logic [1:0]    LAST_DIR  = 2'(NUM_DIRS - 1);
    localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] FLASH_LD  = TW'(FLASH_T - 1);

    state_t              r_state;
    logic [TW-1:0]       r_cnt;
    logic [1:0]          r_dir;
    logic                r_phase;
    logic [NUM_DIRS-1:0] r_latch;
    logic [NUM_DIRS-1:0] r_walk;

    logic [1:0]          w_next_dir;
    logic [NUM_DIRS-1:0] w_next_onehot;
    logic [NUM_DIRS-1:0] w_latch_set;

    // Next approach in round-robin order and its one-hot mask
    assign w_next_dir    = (r_dir == LAST_DIR) ? 2'd0 : r_dir + 2'd1;
    assign w_next_onehot = NUM_DIRS'(1) << w_next_dir;
    // Requests seen this cycle count toward a grant made on this same edge
    assign w_latch_set   = r_latch | ped_req;

    // Sequencer: countdown, state, grant pointer, flash phase, ped latches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_ALL_RED;
            r_cnt   <= ALLRED_LD;
            r_dir   <= LAST_DIR;
            r_phase <= 1'b0;
            r_latch <= '0;
            r_walk  <= '0;
        end else begin
            r_latch <= w_latch_set;
            if (tick) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - TW'(1);
                end else begin
                    case (r_state)
                        S_ALL_RED: begin
                            if (flash_mode) begin
                                r_state <= S_FLASH;
                                r_cnt   <= FLASH_LD;
                                r_phase <= 1'b1;
                            end else begin
                                r_state <= S_GREEN;
                                r_cnt   <= GREEN_LD;
                                r_dir   <= w_next_dir;
                                r_walk  <= w_latch_set & w_next_onehot;
                                r_latch <= w_latch_set & ~w_next_onehot;
                            end
                        end
                        S_GREEN: begin
                            r_state <= S_YELLOW;
                            r_cnt   <= YELLOW_LD;
                            r_walk  <= '0;
                        end
                        S_YELLOW: begin
                            r_state <= S_ALL_RED;
                            r_cnt   <= ALLRED_LD;
                        end
                        S_FLASH: begin
                            if (!flash_mode) begin
                                r_state <= S_ALL_RED;
                                r_cnt   <= ALLRED_LD;
                                r_phase <= 1'b0;
                            end else begin
                                r_phase <= ~r_phase;
                                r_cnt   <= FLASH_LD;
                            end
                        end
                        default: begin
                            r_state <= S_ALL_RED;
                            r_cnt   <= ALLRED_LD;
                        end
                    endcase
                end
            end
        end
    end

    // Lamp decode from registered state only
    always_comb begin
        light = '0;
        for (int d = 0; d < int'(NUM_DIRS); d++) begin
            case (r_state)
                S_GREEN:  light[3*d +: 3] = (2'(d) == r_dir) ? 3'b001 : 3'b100;
                S_YELLOW: light[3*d +: 3] = (2'(d) == r_dir) ? 3'b010 : 3'b100;
                S_FLASH:  light[3*d +: 3] = r_phase ? 3'b100 : 3'b000;
                default:  light[3*d +: 3] = 3'b100;
            endcase
        end
    end

    assign ped_walk   = r_walk;
    assign active_dir = r_dir;

endmodule

// File: tb/tb_traffic_intersection.sv
// Bench for traffic_intersection: directed scenarios plus randomized traffic,
// checked each cycle against a phase/elapsed-time reference model.
module tb_traffic_intersection;

    localparam int N  = 2;
    localparam int GT = 3;
    localparam int YT = 2;
    localparam int AT = 1;
    localparam int FT = 1;

    localparam int P_AR = 0;
    localparam int P_GR = 1;
    localparam int P_YE = 2;
    localparam int P_FL = 3;

    logic         clk;
    logic         rst;
    logic         tick;
    logic [N-1:0] ped_req;
    logic         flash_mode;
    logic [3*N-1:0] light;
    logic [N-1:0] ped_walk;
    logic [1:0]   active_dir;

    int n_checks;
    int n_fail;

    // Reference model: which phase we are in and how many ticks it has lasted
    int       m_phase;
    int       m_elapsed;
    int       m_dir;
    bit       m_flash_on;
    bit [N-1:0] m_latch;
    bit [N-1:0] m_walk;

    traffic_intersection #(
        .NUM_DIRS (N),
        .TW       (4),
        .GREEN_T  (GT),
        .YELLOW_T (YT),
        .ALLRED_T (AT),
        .FLASH_T  (FT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .ped_req    (ped_req),
        .flash_mode (flash_mode),
        .light      (light),
        .ped_walk   (ped_walk),
        .active_dir (active_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dur(input int ph);
        case (ph)
            P_GR:    return GT;
            P_YE:    return YT;
            P_FL:    return FT;
            default: return AT;
        endcase
    endfunction

    function automatic logic [3*N-1:0] exp_light();
        logic [3*N-1:0] e;
        logic [2:0]     s;
        e = '0;
        for (int d = 0; d < N; d++) begin
            if (m_phase == P_GR)      s = (d == m_dir) ? 3'b001 : 3'b100;
            else if (m_phase == P_YE) s = (d == m_dir) ? 3'b010 : 3'b100;
            else if (m_phase == P_FL) s = m_flash_on ? 3'b100 : 3'b000;
            else                      s = 3'b100;
            e[3*d +: 3] = s;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_phase    = P_AR;
        m_elapsed  = 0;
        m_dir      = N - 1;
        m_flash_on = 1'b0;
        m_latch    = '0;
        m_walk     = '0;
    endtask

    task automatic model_edge();
        if (!rst) begin
            model_reset();
            return;
        end
        m_latch = m_latch | ped_req;
        if (tick) begin
            m_elapsed++;
            if (m_elapsed == dur(m_phase)) begin
                m_elapsed = 0;
                case (m_phase)
                    P_AR: begin
                        if (flash_mode) begin
                            m_phase    = P_FL;
                            m_flash_on = 1'b1;
                        end else begin
                            m_dir   = (m_dir + 1) % N;
                            m_phase = P_GR;
                            m_walk  = '0;
                            if (m_latch[m_dir]) m_walk[m_dir] = 1'b1;
                            m_latch[m_dir] = 1'b0;
                        end
                    end
                    P_GR: begin
                        m_phase = P_YE;
                        m_walk  = '0;
                    end
                    P_YE: m_phase = P_AR;
                    default: begin
                        if (!flash_mode) m_phase = P_AR;
                        else             m_flash_on = ~m_flash_on;
                    end
                endcase
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".light"}, 16'(light), 16'(exp_light()));
        check({tag, ".walk"}, 16'(ped_walk), 16'(m_walk));
        check({tag, ".dir"}, 16'(active_dir), 16'(m_dir));
    endtask

    task automatic step(input logic r, input logic t, input logic [N-1:0] p, input logic f,
                        input string tag);
        rst        = r;
        tick       = t;
        ped_req    = p;
        flash_mode = f;
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    // Advance until the model reaches the given phase/approach, bounded
    task automatic wait_for(input int ph, input int dir, input logic f, input string tag);
        int k;
        k = 0;
        while (!(m_phase == ph && m_dir == dir) && k < 60) begin
            step(1'b1, 1'b1, '0, f, tag);
            k++;
        end
        if (!(m_phase == ph && m_dir == dir)) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: timeout waiting for phase %0d dir %0d", tag, ph, dir);
        end
    endtask

    logic [3*N-1:0] seq [14];
    logic           r_flash_rand;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        tick       = 1'b0;
        ped_req    = '0;
        flash_mode = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.light_const", 16'(light), 16'(6'b100_100));
        check("reset.dir_const", 16'(active_dir), 16'(2'd1));

        // Basic cycle after reset release, against a fixed light sequence
        seq = '{6'b100_001, 6'b100_001, 6'b100_001, 6'b100_010, 6'b100_010,
                6'b100_100, 6'b001_100, 6'b001_100, 6'b001_100, 6'b010_100,
                6'b010_100, 6'b100_100, 6'b100_001, 6'b100_001};
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, '0, 1'b0, "seq");
            check("seq.const", 16'(light), 16'(seq[i]));
        end

        // Sparse tick: one tick every third cycle
        for (int i = 0; i < 40; i++)
            step(1'b1, (i % 3) == 2, '0, 1'b0, "slow_tick");

        // Pedestrian requests pulsed during GREEN(0)
        wait_for(P_GR, 0, 1'b0, "ped_wait_g0");
        step(1'b1, 1'b1, 2'b11, 1'b0, "ped_pulse");
        wait_for(P_GR, 1, 1'b0, "ped_wait_g1");
        check("ped.walk_g1", 16'(ped_walk), 16'(2'b10));
        wait_for(P_GR, 0, 1'b0, "ped_wait_g0b");
        check("ped.walk_g0", 16'(ped_walk), 16'(2'b01));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, '0, 1'b0, "ped_tail");

        // Flash request raised in GREEN(0), later dropped
        wait_for(P_GR, 0, 1'b0, "flash_wait_g0");
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, '0, 1'b1, "flash_on");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, '0, 1'b0, "flash_off");

        // Asynchronous reset in YELLOW(1)
        wait_for(P_YE, 1, 1'b0, "rst_wait_y1");
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.light_const", 16'(light), 16'(6'b100_100));
        step(1'b0, 1'b1, '0, 1'b0, "rst_hold");
        step(1'b0, 1'b1, '0, 1'b0, "rst_hold");
        step(1'b1, 1'b1, '0, 1'b0, "rst_release");
        check("rst_release.first_green", 16'(active_dir), 16'(2'd0));

        // Randomized traffic
        r_flash_rand = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] p;
            logic         r;
            if ($urandom_range(0, 40) == 0) r_flash_rand = ~r_flash_rand;
            p = '0;
            for (int d = 0; d < N; d++) p[d] = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 250) != 0);
            step(r, $urandom_range(0, 3) != 0, p, r_flash_rand, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_intersection.md
TRAFFIC_INTERSECTION -- requirements
Module: traffic_intersection

Interface
REQ-001 Parameter NUM_DIRS, default 2, SHALL set the number of approaches served round-robin, legal range 2..4.
REQ-002 Parameter TW, default 4, SHALL set the internal countdown width; it SHALL hold the largest duration minus 1.
REQ-003 Parameter GREEN_T, default 6, SHALL set green duration in ticks, legal range >= 1.
REQ-004 Parameter YELLOW_T, default 2, SHALL set yellow duration in ticks, legal range >= 1.
REQ-005 Parameter ALLRED_T, default 1, SHALL set all-red clearance duration in ticks, legal range >= 1.
REQ-006 Parameter FLASH_T, default 1, SHALL set flash half-period in ticks, legal range >= 1.
REQ-007 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-008 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-009 tick  input  1  SHALL be the time-base enable; countdown SHALL advance only on cycles with tick=1.
REQ-010 ped_req  input  NUM_DIRS  SHALL be the per-approach pedestrian request, level-sampled each cycle.
REQ-011 flash_mode  input  1  SHALL be the fault/night flashing-mode request.
REQ-012 light  output  3*NUM_DIRS  SHALL be the per-approach lamp field; slice d is {red,yellow,green} at bits [3d+2:3d].
REQ-013 ped_walk  output  NUM_DIRS  SHALL be the per-approach walk signal.
REQ-014 active_dir  output  2  SHALL be the index of the approach currently or most recently granted green.

Function
REQ-015 The FSM SHALL have states ALL_RED, GREEN, YELLOW and FLASH.
REQ-016 On entering any state, the countdown SHALL load (duration-1). On a tick with countdown=0, the state SHALL transition; otherwise a tick SHALL decrement the countdown. tick=0 SHALL freeze the state and the countdown.
REQ-017 Each state SHALL therefore last exactly its duration in ticks: GREEN_T, YELLOW_T, ALLRED_T or FLASH_T.
REQ-018 The normal sequence SHALL be ALL_RED -> GREEN(dir) -> YELLOW(dir) -> ALL_RED -> GREEN((dir+1) mod NUM_DIRS).
REQ-019 On each ALL_RED -> GREEN transition, active_dir SHALL advance, wrapping from NUM_DIRS-1 to 0.
REQ-020 The first GREEN after reset SHALL go to approach 0.
REQ-021 In GREEN, slice active_dir SHALL be 001 and all other slices 100.
REQ-022 In YELLOW, slice active_dir SHALL be 010 and all other slices 100.
REQ-023 In ALL_RED, every slice SHALL be 100.
REQ-024 light SHALL be a pure decode of the registered state, active_dir and flash phase; no other glitch source SHALL drive it.
REQ-025 A per-approach ped latch SHALL set on any cycle with ped_req[d]=1.
REQ-026 On entering GREEN for approach d, ped_walk[d] SHALL assert if latch[d] or ped_req[d] is 1 on that cycle, and latch[d] SHALL clear.
REQ-027 ped_walk[d] SHALL deassert on leaving GREEN.
REQ-028 A ped_req[d] during GREEN(d) SHALL be held in the latch for the next GREEN(d) only.
REQ-029 ped_walk SHALL be 0 outside GREEN; at most one bit SHALL be set at a time.
REQ-030 flash_mode SHALL be evaluated only at ALL_RED expiry; if 1, the FSM SHALL enter FLASH instead of GREEN, and active_dir SHALL be unchanged.
REQ-031 flash_mode asserted during GREEN or YELLOW SHALL NOT truncate those states; the full yellow and all-red clearance SHALL complete first.
REQ-032 FLASH SHALL toggle a phase bit every FLASH_T ticks: phase 1 sets every slice to 100, phase 0 sets every slice to 000. FLASH SHALL enter with phase 1.
REQ-033 FLASH SHALL exit, only at a half-period expiry with flash_mode=0 sampled, to ALL_RED with full ALLRED_T. The next green SHALL be (active_dir+1) mod NUM_DIRS.
REQ-034 ped latches SHALL keep capturing in FLASH; ped_walk SHALL stay 0 in FLASH.

Reset
REQ-035 rst=0 SHALL immediately force state ALL_RED, countdown ALLRED_T-1, active_dir to NUM_DIRS-1 (so the first grant is 0), flash phase 0, ped latches 0, ped_walk 0 and light all 100.
REQ-036 Reset asserted mid-GREEN SHALL force all-red within the same cycle, without a yellow phase.
REQ-037 The first tick after rst release SHALL count toward the ALL_RED duration.

Verification (NUM_DIRS=2, GREEN_T=3, YELLOW_T=2, ALLRED_T=1, FLASH_T=1, tick=1 always unless stated)
REQ-038 Release reset -> light sequence 100_100 x1, 100_001 x3, 100_010 x2, 100_100 x1, 001_100 x3, 010_100 x2, then repeat from 100_001; active_dir 0,1,0.
REQ-039 tick=1 only every 3rd cycle -> every state lasts 3x its duration in clocks; light is frozen between ticks.
REQ-040 Pulse ped_req=2'b10 for 1 cycle during GREEN(0) -> ped_walk=2'b10 for exactly the 3 ticks of GREEN(1), then 0. ped_req[0] pulsed during GREEN(0) -> walk[0] only at the following GREEN(0).
REQ-041 Assert flash_mode during GREEN(0) -> GREEN(0) and YELLOW complete, ALL_RED for 1 tick, then light alternates 100_100/000_000 each tick. Drop flash_mode -> ALL_RED, then GREEN(1).
REQ-042 Assert rst mid-YELLOW(1), hold 2 cycles, release -> light=100_100 asynchronously, ped_walk=0, and the next GREEN is approach 0.
